// File: rtl/volume_history_meter.sv
// volume_history_meter: scrolling level-history bargraph with peak-hold marker and sequenced clear for the OLED status screen.
module volume_history_meter #(
    parameter int NUM_COLS     = 16,
    parameter int LEVELS       = 16,
    parameter int LEVEL_W      = 4,
    parameter int X0           = 43,
    parameter int COL_PITCH    = 3,
    parameter int COL_W        = 2,
    parameter int Y_BOTTOM     = 52,
    parameter int ROW_PITCH    = 3,
    parameter int HOLD_SAMPLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [LEVEL_W-1:0] sample_level,
    input  logic               freeze,
    input  logic               clear,
    input  logic [6:0]         x,
    input  logic [5:0]         y,
    output logic               busy,
    output logic [15:0]        oled_data
);
    localparam int PW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam logic [15:0] PAL [8] = '{16'h8204, 16'hF800, 16'hFC00, 16'hFFE0,
                                        16'h07E0, 16'h5FFF, 16'h001F, 16'hF81F};
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nx;
    logic [LEVEL_W-1:0] hist [NUM_COLS];
    logic [PW-1:0]      wp;
    logic [LEVEL_W-1:0] peak;
    logic [HW-1:0]      hold;
    logic               accept, wp_last;
    logic [LEVEL_W-1:0] lvl, cur;
    logic [PW-1:0]      idx;
    logic [2:0]         band;
    logic               in_col, in_seg;
    logic [15:0]        pix;
    int                 dx, dy, col, seg;
    always_comb begin
        wp_last  = wp == PW'(NUM_COLS - 1);
        state_nx = state == IDLE ? (clear ? CLEAR : IDLE) : (wp_last ? IDLE : CLEAR);
        accept   = state == IDLE && sample_valid && !freeze && !clear;
        lvl      = sample_level > LEVEL_W'(LEVELS - 1) ? LEVEL_W'(LEVELS - 1) : sample_level;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wp    <= '0;
            peak  <= '0;
            hold  <= '0;
            for (int i = 0; i < NUM_COLS; i++) hist[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) begin
                hist[wp] <= '0;
                wp       <= wp_last ? '0 : wp + PW'(1);
                if (wp_last) begin
                    peak <= '0;
                    hold <= '0;
                end
            end else if (clear) begin
                wp <= '0;
            end else if (accept) begin
                hist[wp] <= lvl;
                wp       <= wp_last ? '0 : wp + PW'(1);
                if (lvl >= peak) begin
                    peak <= lvl;
                    hold <= HW'(HOLD_SAMPLES);
                end else if (hold != '0)
                    hold <= hold - HW'(1);
                else if (peak != '0)
                    peak <= peak - LEVEL_W'(1);
            end
        end
    end
    // Locate the pixel within the bar/segment grid; gaps between cells fall through to background.
    always_comb begin
        dx     = int'(x) - X0;
        dy     = Y_BOTTOM - int'(y);
        col    = dx / COL_PITCH;
        seg    = dy / ROW_PITCH;
        in_col = dx >= 0 && dx % COL_PITCH < COL_W;
        in_seg = dy >= 0 && dy % ROW_PITCH <= ROW_PITCH - 2 && seg < LEVELS;
        idx    = PW'((int'(wp) + col) % NUM_COLS);
        cur    = hist[idx];
        band   = 3'(seg * 8 / LEVELS);
        pix    = !(in_col && in_seg) ? 16'hFFFF :
                 col < NUM_COLS      ? (int'(cur) >= seg ? PAL[band] : 16'hFFFF) :
                 col == NUM_COLS && int'(peak) == seg ? 16'h0000 : 16'hFFFF;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) oled_data <= 16'hFFFF;
        else        oled_data <= pix;
    assign busy = state == CLEAR;
endmodule

// File: tb/tb_volume_history_meter.sv
// tb_volume_history_meter: scoreboard bench comparing the meter against a geometric reference model.
module tb_volume_history_meter;
    logic        clk = 0, rst_n = 0;
    logic        sample_valid = 0, freeze = 0, clear = 0, busy;
    logic [3:0]  sample_level = 0;
    logic [6:0]  x = 0;
    logic [5:0]  y = 0;
    logic [15:0] oled_data;
    int          vectors = 0, miscompares = 0;
    logic [15:0] exp_q [$];
    int          m_hist [16];
    int          m_wp, m_peak, m_hold;
    bit          m_clr;
    logic [15:0] band_col [8] = '{16'h8204, 16'hF800, 16'hFC00, 16'hFFE0,
                                  16'h07E0, 16'h5FFF, 16'h001F, 16'hF81F};

    volume_history_meter dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_level(sample_level),
        .freeze(freeze), .clear(clear), .x(x), .y(y), .busy(busy), .oled_data(oled_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] model_pix(input int px, input int py);
        logic [15:0] p = 16'hFFFF;
        for (int c = 0; c < 16; c++)
            if (px >= 43 + 3 * c && px <= 44 + 3 * c)
                for (int j = 0; j < 16; j++)
                    if (py >= 51 - 3 * j && py <= 52 - 3 * j && m_hist[(m_wp + c) % 16] >= j)
                        p = band_col[j / 2];
        if (px >= 91 && px <= 92 && py >= 51 - 3 * m_peak && py <= 52 - 3 * m_peak) p = 16'h0000;
        return p;
    endfunction

    task automatic model_reset();
        foreach (m_hist[i]) m_hist[i] = 0;
        m_wp = 0; m_peak = 0; m_hold = 0; m_clr = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit sv, input int lv, input bit fr, input bit cl);
        int l;
        if (m_clr) begin
            m_hist[m_wp] = 0;
            if (m_wp == 15) begin
                m_wp = 0; m_peak = 0; m_hold = 0; m_clr = 0;
            end else m_wp++;
        end else if (cl) begin
            m_clr = 1; m_wp = 0;
        end else if (sv && !fr) begin
            l = lv > 15 ? 15 : lv;
            m_hist[m_wp] = l;
            m_wp = (m_wp + 1) % 16;
            if (l >= m_peak) begin
                m_peak = l; m_hold = 8;
            end else if (m_hold > 0) m_hold--;
            else if (m_peak > 0) m_peak--;
        end
    endtask

    task automatic cyc(input int px, input int py, input bit sv, input int lv, input bit fr, input bit cl);
        x = 7'(px); y = 6'(py); sample_valid = sv; sample_level = 4'(lv); freeze = fr; clear = cl;
        exp_q.push_back(model_pix(px, py));
        model_edge(sv, lv, fr, cl);
        @(posedge clk); #1;
        check("pix", oled_data, exp_q.pop_front());
        check("busy", {15'd0, busy}, {15'd0, m_clr});
        sample_valid = 0; clear = 0;
    endtask

    task automatic sample(input int lv);
        cyc(0, 0, 1, lv, 0, 0);
    endtask

    task automatic scan_all();
        for (int py = 0; py < 64; py++)
            for (int px = 0; px < 96; px++) cyc(px, py, 0, 0, freeze, 0);
    endtask

    task automatic scan_col(input int px);
        for (int py = 0; py < 64; py++) cyc(px, py, 0, 0, freeze, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 0;
        model_reset();
        #1;
        check("rst_busy", {15'd0, busy}, 16'h0000);
        check("rst_pix", oled_data, 16'hFFFF);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        do_reset();
        scan_all();
        for (int i = 0; i < 16; i++) sample(i);
        for (int i = 0; i < 17; i++) sample(3);
        scan_all();
        do_reset();
        sample(15);
        scan_col(88);
        scan_col(91);
        do_reset();
        sample(12);
        scan_col(91);
        for (int i = 0; i < 12; i++) begin
            sample(0);
            scan_col(91);
        end
        for (int i = 0; i < 4; i++) sample(i * 4 + 2);
        freeze = 1;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 9, 1, 0);
        scan_all();
        freeze = 0;
        sample(7);
        scan_col(88);
        scan_col(91);
        cyc(88, 40, 1, 11, 0, 1);
        for (int i = 0; i < 18; i++) cyc(88, 40 + i, 1, 14, 0, 0);
        scan_all();
        sample(5);
        scan_col(88);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
        do_reset();
        scan_col(91);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
